acc_cmdin_receiver: RTL and testbench

- Accelerator-side terminator of the cmdin AXI-Stream produced by the OmpSs Manager interconnect.
- Parses each command into a local task descriptor and holds it for the accelerator core behind a valid/ready handshake.
- Command types: EXEC_TASK_CODE, EXEC_PERI_TASK_CODE, SETUP_HW_INST_CODE.
- Flags protocol violations with a sticky error and recovers at the next tlast.

---
 rtl/acc_cmdin_receiver_if.sv | 17 +
 rtl/acc_cmdin_receiver.sv | 244 ++++++++++++++++++++++++
 tb/tb_acc_cmdin_receiver.sv | 386 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/acc_cmdin_receiver_if.sv
// acc_cmdin_receiver_if
//   cmdin AXI-Stream bundle between the OmpSs Manager interconnect (master)
//   and the accelerator-side command receiver (slave).
//   tvalid/tready : beat handshake
//   tdata         : 64-bit command word
//   tlast         : final beat of a command
//   tdest         : destination accelerator id
interface acc_cmdin_receiver_if;
  logic        tvalid;
  logic        tready;
  logic [63:0] tdata;
  logic        tlast;
  logic [7:0]  tdest;

  modport master (output tvalid, tdata, tlast, tdest, input tready);
  modport slave  (input tvalid, tdata, tlast, tdest, output tready);
endinterface

// File: rtl/acc_cmdin_receiver.sv
// acc_cmdin_receiver
//   Terminates the cmdin stream, parses EXEC / EXEC_PERI / SETUP_HW_INST
//   commands into a local task descriptor plus argument/flag store, and
//   holds the descriptor for the core behind task_valid/task_ready.
//   Ports:
//     clk, rst            : clock, synchronous active-high reset
//     cmdin (slave)       : command stream
//     task_*              : descriptor and its valid/ready handshake
//     arg_raddr/rdata/rflag : registered argument store read port (1 cycle)
//     inst_*              : instrumentation setup (inst_valid is a 1-cycle pulse)
//     err / err_clr       : sticky protocol error and its clear (set wins)
//
// state   | meaning
// --------+-----------------------------------------------------------
// HEADER  | waiting for the command header beat
// TID     | expecting task id (or instrumentation buffer address)
// PTID    | expecting parent task id
// PERIOD  | expecting {period, repetitions} of a periodic task
// ARGFLAG | expecting {arg index, flag byte} for argument argidx
// ARG     | expecting the 64-bit value of argument argidx
// BUSY    | descriptor presented to the core, stream stalled
// DRAIN   | discarding the rest of a bad command up to tlast
module acc_cmdin_receiver #(
  parameter int         MAX_ARGS = 15,
  parameter logic [7:0] ACC_ID   = 8'd0
) (
  input  logic        clk,
  input  logic        rst,
  acc_cmdin_receiver_if.slave cmdin,
  output logic        task_valid,
  input  logic        task_ready,
  output logic [7:0]  task_code,
  output logic        task_comp,
  output logic [3:0]  task_nargs,
  output logic [63:0] task_tid,
  output logic [63:0] task_ptid,
  output logic [31:0] task_period,
  output logic [31:0] task_nrep,
  input  logic [3:0]  arg_raddr,
  output logic [63:0] arg_rdata,
  output logic [7:0]  arg_rflag,
  output logic        inst_valid,
  output logic [63:0] inst_addr,
  output logic [23:0] inst_slots,
  output logic        err,
  input  logic        err_clr
);

  localparam logic [7:0] EXEC_TASK_CODE      = 8'h01;
  localparam logic [7:0] SETUP_HW_INST_CODE  = 8'h02;
  localparam logic [7:0] EXEC_PERI_TASK_CODE = 8'h05;
  localparam int CMD_TYPE_L      = 0;
  localparam int CMD_TYPE_H      = 7;
  localparam int NUM_ARGS_OFFSET = 8;
  localparam int COMPF_L         = 32;
  localparam int COMPF_H         = 32;
  localparam int ARG_FLAG_L      = 0;
  localparam int ARG_FLAG_H      = 7;
  localparam logic [7:0] MAX_ARGS_B = 8'(MAX_ARGS);
  localparam logic [4:0] MAX_ARGS_W = 5'(MAX_ARGS);

  typedef enum logic [2:0] {
    S_HEADER, S_TID, S_PTID, S_PERIOD, S_ARGFLAG, S_ARG, S_BUSY, S_DRAIN
  } state_t;

  state_t      state_q, state_d;
  logic        err_set;
  logic        tready_q, task_valid_q, inst_valid_q, err_q;
  logic [7:0]  code_q, nargs_q;
  logic        comp_q;
  logic [23:0] slots_q;
  logic [63:0] tid_q, ptid_q, inst_addr_q;
  logic [31:0] period_q, nrep_q;
  logic [23:0] inst_slots_q;
  logic [3:0]  argidx_q;
  logic [63:0] arg_mem [MAX_ARGS];
  logic [7:0]  flag_mem [MAX_ARGS];
  logic [63:0] arg_rdata_q;
  logic [7:0]  arg_rflag_q;

  logic       beat, hdr_ok, last_arg, idx_ok;
  logic [7:0] hdr_code, hdr_nargs;

  assign beat      = cmdin.tvalid && tready_q;
  assign hdr_code  = cmdin.tdata[CMD_TYPE_H:CMD_TYPE_L];
  assign hdr_nargs = cmdin.tdata[NUM_ARGS_OFFSET +: 8];
  assign last_arg  = (({4'd0, argidx_q} + 8'd1) == nargs_q);
  assign idx_ok    = (cmdin.tdata[63:32] == {28'd0, argidx_q});

  // The SETUP header carries the slot count over the nargs field, so the
  // argument-count limit only applies to task commands.
  always_comb begin
    hdr_ok = 1'b0;
    if (cmdin.tdest == ACC_ID) begin
      if (hdr_code == SETUP_HW_INST_CODE)
        hdr_ok = 1'b1;
      else if (hdr_code == EXEC_TASK_CODE || hdr_code == EXEC_PERI_TASK_CODE)
        hdr_ok = (hdr_nargs <= MAX_ARGS_B);
    end
  end

  // Every error exits to DRAIN, unless the offending beat was itself the
  // last one, in which case the next beat is already a new header.
  always_comb begin
    state_d = state_q;
    err_set = 1'b0;
    unique case (state_q)
      S_HEADER: if (beat) begin
        if (cmdin.tlast) err_set = 1'b1;
        else if (!hdr_ok) begin err_set = 1'b1; state_d = S_DRAIN; end
        else state_d = S_TID;
      end
      S_TID: if (beat) begin
        if (code_q == SETUP_HW_INST_CODE) begin
          if (cmdin.tlast) state_d = S_HEADER;
          else begin err_set = 1'b1; state_d = S_DRAIN; end
        end else if (cmdin.tlast) begin
          err_set = 1'b1; state_d = S_HEADER;
        end else state_d = S_PTID;
      end
      S_PTID, S_PERIOD: if (beat) begin
        if (state_q == S_PTID && code_q == EXEC_PERI_TASK_CODE) begin
          if (cmdin.tlast) begin err_set = 1'b1; state_d = S_HEADER; end
          else state_d = S_PERIOD;
        end else if (nargs_q != 8'd0) begin
          if (cmdin.tlast) begin err_set = 1'b1; state_d = S_HEADER; end
          else state_d = S_ARGFLAG;
        end else if (cmdin.tlast) state_d = S_BUSY;
        else begin err_set = 1'b1; state_d = S_DRAIN; end
      end
      S_ARGFLAG: if (beat) begin
        if (cmdin.tlast) begin err_set = 1'b1; state_d = S_HEADER; end
        else if (!idx_ok) begin err_set = 1'b1; state_d = S_DRAIN; end
        else state_d = S_ARG;
      end
      S_ARG: if (beat) begin
        if (last_arg) begin
          if (cmdin.tlast) state_d = S_BUSY;
          else begin err_set = 1'b1; state_d = S_DRAIN; end
        end else if (cmdin.tlast) begin
          err_set = 1'b1; state_d = S_HEADER;
        end else state_d = S_ARGFLAG;
      end
      S_BUSY:  if (task_ready) state_d = S_HEADER;
      S_DRAIN: if (beat && cmdin.tlast) state_d = S_HEADER;
      default: state_d = S_HEADER;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_HEADER;
      tready_q     <= 1'b0;
      task_valid_q <= 1'b0;
      inst_valid_q <= 1'b0;
      err_q        <= 1'b0;
      code_q       <= '0;
      nargs_q      <= '0;
      comp_q       <= 1'b0;
      slots_q      <= '0;
      tid_q        <= '0;
      ptid_q       <= '0;
      period_q     <= '0;
      nrep_q       <= 32'd1;
      argidx_q     <= '0;
      inst_addr_q  <= '0;
      inst_slots_q <= '0;
    end else begin
      state_q      <= state_d;
      tready_q     <= (state_d != S_BUSY);
      task_valid_q <= (state_d == S_BUSY);
      inst_valid_q <= 1'b0;
      if (err_clr) err_q <= 1'b0;
      if (err_set) err_q <= 1'b1;

      if (beat) begin
        unique case (state_q)
          S_HEADER: if (state_d == S_TID) begin
            code_q   <= hdr_code;
            nargs_q  <= hdr_nargs;
            comp_q   <= cmdin.tdata[COMPF_H:COMPF_L];
            slots_q  <= cmdin.tdata[31:8];
            period_q <= '0;
            nrep_q   <= 32'd1;
            argidx_q <= '0;
          end
          S_TID: begin
            tid_q <= cmdin.tdata;
            if (code_q == SETUP_HW_INST_CODE && !err_set) begin
              inst_addr_q  <= cmdin.tdata;
              inst_slots_q <= slots_q;
              inst_valid_q <= 1'b1;
            end
          end
          S_PTID:   ptid_q <= cmdin.tdata;
          S_PERIOD: begin
            period_q <= cmdin.tdata[63:32];
            nrep_q   <= cmdin.tdata[31:0];
          end
          S_ARG:    argidx_q <= argidx_q + 4'd1;
          default:  ;
        endcase
      end
    end
  end

  // Argument store: no reset, contents after reset are don't-care.
  always_ff @(posedge clk) begin
    if (beat && state_q == S_ARGFLAG && !cmdin.tlast && idx_ok)
      flag_mem[argidx_q] <= cmdin.tdata[ARG_FLAG_H:ARG_FLAG_L];
    if (beat && state_q == S_ARG)
      arg_mem[argidx_q] <= cmdin.tdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      arg_rdata_q <= '0;
      arg_rflag_q <= '0;
    end else if ({1'b0, arg_raddr} < MAX_ARGS_W) begin
      arg_rdata_q <= arg_mem[arg_raddr];
      arg_rflag_q <= flag_mem[arg_raddr];
    end else begin
      arg_rdata_q <= '0;
      arg_rflag_q <= '0;
    end
  end

  assign cmdin.tready = tready_q;
  assign task_valid   = task_valid_q;
  assign task_code    = code_q;
  assign task_comp    = comp_q;
  assign task_nargs   = nargs_q[3:0];
  assign task_tid     = tid_q;
  assign task_ptid    = ptid_q;
  assign task_period  = period_q;
  assign task_nrep    = nrep_q;
  assign arg_rdata    = arg_rdata_q;
  assign arg_rflag    = arg_rflag_q;
  assign inst_valid   = inst_valid_q;
  assign inst_addr    = inst_addr_q;
  assign inst_slots   = inst_slots_q;
  assign err          = err_q;

endmodule

// File: tb/tb_acc_cmdin_receiver.sv
module tb_acc_cmdin_receiver;

  localparam logic [7:0] EXEC  = 8'h01;
  localparam logic [7:0] SETUP = 8'h02;
  localparam logic [7:0] PERI  = 8'h05;

  typedef struct packed {
    logic [7:0]        code;
    logic              comp;
    logic [3:0]        nargs;
    logic [63:0]       tid;
    logic [63:0]       ptid;
    logic [31:0]       period;
    logic [31:0]       nrep;
    logic [14:0][63:0] args;
    logic [14:0][7:0]  flags;
  } cmd_t;

  logic        clk, rst, task_ready, err_clr;
  logic [3:0]  arg_raddr;
  logic        task_valid, task_comp, inst_valid, err;
  logic [7:0]  task_code, arg_rflag;
  logic [3:0]  task_nargs;
  logic [63:0] task_tid, task_ptid, arg_rdata, inst_addr;
  logic [31:0] task_period, task_nrep;
  logic [23:0] inst_slots;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] bq[$];

  acc_cmdin_receiver_if cmdin_if ();

  acc_cmdin_receiver #(.MAX_ARGS(15), .ACC_ID(8'd0)) dut (
    .clk(clk), .rst(rst), .cmdin(cmdin_if.slave),
    .task_valid(task_valid), .task_ready(task_ready), .task_code(task_code),
    .task_comp(task_comp), .task_nargs(task_nargs), .task_tid(task_tid),
    .task_ptid(task_ptid), .task_period(task_period), .task_nrep(task_nrep),
    .arg_raddr(arg_raddr), .arg_rdata(arg_rdata), .arg_rflag(arg_rflag),
    .inst_valid(inst_valid), .inst_addr(inst_addr), .inst_slots(inst_slots),
    .err(err), .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] hdr(input logic [7:0] code, input logic [7:0] nargs,
                                      input logic comp);
    return {31'd0, comp, 16'd0, nargs, code};
  endfunction

  function automatic cmd_t rand_cmd(input logic [7:0] code, input int nargs);
    cmd_t c;
    c.code   = code;
    c.comp   = 1'($urandom);
    c.nargs  = 4'(nargs);
    c.tid    = {$urandom, $urandom};
    c.ptid   = {$urandom, $urandom};
    c.period = $urandom;
    c.nrep   = $urandom;
    for (int i = 0; i < 15; i++) begin
      c.args[i]  = {$urandom, $urandom};
      c.flags[i] = 8'($urandom);
    end
    return c;
  endfunction

  // Wire format of a task command, straight from the command layout rules.
  task automatic build_beats(input cmd_t c);
    bq.delete();
    bq.push_back(hdr(c.code, {4'd0, c.nargs}, c.comp));
    bq.push_back(c.tid);
    bq.push_back(c.ptid);
    if (c.code == PERI) bq.push_back({c.period, c.nrep});
    for (int i = 0; i < int'(c.nargs); i++) begin
      bq.push_back({32'(i), 24'd0, c.flags[i]});
      bq.push_back(c.args[i]);
    end
  endtask

  // Called at a negedge; returns at the negedge after the beat was taken.
  task automatic send_beat(input logic [63:0] d, input logic l, input logic [7:0] dest);
    int n = 0;
    repeat ($urandom_range(0, 1)) @(negedge clk);
    cmdin_if.tvalid = 1'b1;
    cmdin_if.tdata  = d;
    cmdin_if.tlast  = l;
    cmdin_if.tdest  = dest;
    while (!cmdin_if.tready && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin
      n_checks++; n_fail++;
      $display("FAIL beat_accept: tready stuck at %0b, required 1", cmdin_if.tready);
    end
    @(negedge clk);
    cmdin_if.tvalid = 1'b0;
    cmdin_if.tlast  = 1'b0;
  endtask

  task automatic send_cmd();
    for (int i = 0; i < bq.size(); i++) send_beat(bq[i], i == bq.size() - 1, 8'd0);
  endtask

  task automatic expect_task(input cmd_t c, input string tag, input int ready_dly);
    int n = 0;
    logic [31:0] e_per, e_rep;
    e_per = (c.code == PERI) ? c.period : 32'd0;
    e_rep = (c.code == PERI) ? c.nrep : 32'd1;
    while (!task_valid && n < 50) begin @(negedge clk); n++; end
    n_checks++;
    if (task_valid !== 1'b1) begin n_fail++; $display("FAIL %s task_valid: got %b want 1", tag, task_valid); end
    n_checks++;
    if (task_code !== c.code) begin n_fail++; $display("FAIL %s code: got %h want %h", tag, task_code, c.code); end
    n_checks++;
    if (task_comp !== c.comp) begin n_fail++; $display("FAIL %s comp: got %b want %b", tag, task_comp, c.comp); end
    n_checks++;
    if (task_nargs !== c.nargs) begin n_fail++; $display("FAIL %s nargs: got %0d want %0d", tag, task_nargs, c.nargs); end
    n_checks++;
    if (task_tid !== c.tid) begin n_fail++; $display("FAIL %s tid: got %h want %h", tag, task_tid, c.tid); end
    n_checks++;
    if (task_ptid !== c.ptid) begin n_fail++; $display("FAIL %s ptid: got %h want %h", tag, task_ptid, c.ptid); end
    n_checks++;
    if (task_period !== e_per) begin n_fail++; $display("FAIL %s period: got %0d want %0d", tag, task_period, e_per); end
    n_checks++;
    if (task_nrep !== e_rep) begin n_fail++; $display("FAIL %s nrep: got %0d want %0d", tag, task_nrep, e_rep); end
    for (int i = int'(c.nargs) - 1; i >= 0; i--) begin
      arg_raddr = 4'(i);
      @(negedge clk);
      n_checks++;
      if (arg_rdata !== c.args[i] || arg_rflag !== c.flags[i]) begin
        n_fail++;
        $display("FAIL %s arg%0d: got %h/%h want %h/%h", tag, i, arg_rdata, arg_rflag, c.args[i], c.flags[i]);
      end
    end
    repeat (ready_dly) @(negedge clk);
    n_checks++;
    if (task_valid !== 1'b1 || cmdin_if.tready !== 1'b0) begin
      n_fail++; $display("FAIL %s hold: valid %b tready %b want 1/0", tag, task_valid, cmdin_if.tready);
    end
    task_ready = 1'b1;
    @(negedge clk);
    task_ready = 1'b0;
    n_checks++;
    if (task_valid !== 1'b0 || cmdin_if.tready !== 1'b1) begin
      n_fail++; $display("FAIL %s release: valid %b tready %b want 0/1", tag, task_valid, cmdin_if.tready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (cmdin_if.tready !== 1'b0) begin n_fail++; $display("FAIL rst_tready: got %b want 0", cmdin_if.tready); end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (cmdin_if.tready !== 1'b1 || task_valid !== 1'b0 || inst_valid !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_ctrl: tready %b valid %b inst %b err %b want 1/0/0/0",
               cmdin_if.tready, task_valid, inst_valid, err);
    end
    n_checks++;
    if (task_tid !== 64'd0 || task_ptid !== 64'd0 || task_period !== 32'd0 || task_nrep !== 32'd1 ||
        task_code !== 8'd0 || task_nargs !== 4'd0 || inst_addr !== 64'd0 || inst_slots !== 24'd0) begin
      n_fail++;
      $display("FAIL rst_desc: tid %h nrep %0d period %0d code %h want 0/1/0/0", task_tid, task_nrep,
               task_period, task_code);
    end
  endtask

  task automatic test_exec();
    cmd_t c;
    c = rand_cmd(EXEC, 2);
    c.comp  = 1'b0;
    c.tid   = 64'h0000_0005_0000_0001;
    c.ptid  = 64'h2A;
    c.args[0] = 64'h1000; c.flags[0] = 8'h30;
    c.args[1] = 64'h2000; c.flags[1] = 8'h10;
    build_beats(c);
    send_cmd();
    expect_task(c, "exec", 2);
  endtask

  task automatic test_peri();
    cmd_t c;
    c = rand_cmd(PERI, 0);
    c.period = 32'd100;
    c.nrep   = 32'd7;
    build_beats(c);
    send_cmd();
    expect_task(c, "peri", 0);
  endtask

  task automatic test_inst();
    int pulses = 0;
    send_beat({32'd0, 24'h40, SETUP}, 1'b0, 8'd0);
    send_beat(64'h8000_0000, 1'b1, 8'd0);
    n_checks++;
    if (inst_valid !== 1'b1 || inst_addr !== 64'h8000_0000 || inst_slots !== 24'h40) begin
      n_fail++;
      $display("FAIL inst: valid %b addr %h slots %h want 1/80000000/40", inst_valid, inst_addr, inst_slots);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (inst_valid) pulses++;
      if (task_valid) pulses += 100;
    end
    n_checks++;
    if (pulses != 0) begin n_fail++; $display("FAIL inst_pulse: extra activity %0d want 0", pulses); end
  endtask

  task automatic test_bad_index();
    cmd_t c;
    int seen = 0;
    c = rand_cmd(EXEC, 2);
    build_beats(c);
    bq[3][63:32] = 32'd1;
    for (int i = 0; i < bq.size(); i++) begin
      send_beat(bq[i], i == bq.size() - 1, 8'd0);
      if (task_valid) seen++;
      if (i == 3) begin
        n_checks++;
        if (err !== 1'b1) begin n_fail++; $display("FAIL badidx_err: got %b want 1", err); end
      end
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (seen != 0 || task_valid !== 1'b0 || err !== 1'b1) begin
      n_fail++; $display("FAIL badidx_drain: valid seen %0d err %b want 0/1", seen, err);
    end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL err_clr: got %b want 0", err); end
    c = rand_cmd(EXEC, 1);
    build_beats(c);
    send_cmd();
    expect_task(c, "after_badidx", 1);
  endtask

  task automatic test_header_errors();
    cmd_t c;
    // set wins over clear in the same cycle
    err_clr = 1'b1;
    send_beat(hdr(EXEC, 8'd0, 1'b0), 1'b1, 8'd0);
    err_clr = 1'b0;
    n_checks++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL err_setwins: got %b want 1", err); end
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
    // nargs above the store size
    send_beat(hdr(EXEC, 8'd16, 1'b0), 1'b0, 8'd0);
    send_beat(64'h1, 1'b0, 8'd0);
    send_beat(64'h2, 1'b1, 8'd0);
    n_checks++;
    if (err !== 1'b1 || task_valid !== 1'b0) begin
      n_fail++; $display("FAIL nargs16: err %b valid %b want 1/0", err, task_valid);
    end
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
    // other accelerator's command
    send_beat(hdr(EXEC, 8'd0, 1'b0), 1'b0, 8'd3);
    send_beat(64'h1, 1'b0, 8'd3);
    send_beat(64'h2, 1'b1, 8'd3);
    n_checks++;
    if (err !== 1'b1 || task_valid !== 1'b0) begin
      n_fail++; $display("FAIL tdest: err %b valid %b want 1/0", err, task_valid);
    end
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
    // missing tlast on the final beat; the extra beat must be drained
    send_beat(hdr(EXEC, 8'd0, 1'b0), 1'b0, 8'd0);
    send_beat(64'h11, 1'b0, 8'd0);
    send_beat(64'h22, 1'b0, 8'd0);
    send_beat(hdr(EXEC, 8'd0, 1'b0), 1'b1, 8'd0);
    n_checks++;
    if (err !== 1'b1 || task_valid !== 1'b0) begin
      n_fail++; $display("FAIL no_tlast: err %b valid %b want 1/0", err, task_valid);
    end
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
    // premature tlast goes straight back to HEADER: next command must decode
    send_beat(hdr(EXEC, 8'd1, 1'b0), 1'b0, 8'd0);
    send_beat(64'h11, 1'b0, 8'd0);
    send_beat(64'h22, 1'b1, 8'd0);
    n_checks++;
    if (err !== 1'b1 || task_valid !== 1'b0) begin
      n_fail++; $display("FAIL early_tlast: err %b valid %b want 1/0", err, task_valid);
    end
    c = rand_cmd(PERI, 2);
    build_beats(c);
    send_cmd();
    expect_task(c, "after_early", 0);
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
  endtask

  task automatic test_back_to_back();
    cmd_t c1, c2;
    int bad = 0;
    c1 = rand_cmd(EXEC, 1);
    c2 = rand_cmd(EXEC, 1);
    build_beats(c1);
    send_cmd();
    build_beats(c2);
    cmdin_if.tvalid = 1'b1;
    cmdin_if.tdata  = bq[0];
    cmdin_if.tlast  = 1'b0;
    cmdin_if.tdest  = 8'd0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (cmdin_if.tready !== 1'b0 || task_valid !== 1'b1 || task_tid !== c1.tid) bad++;
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL b2b_stall: %0d bad cycles want 0", bad); end
    task_ready = 1'b1;
    @(negedge clk);
    task_ready = 1'b0;
    n_checks++;
    if (cmdin_if.tready !== 1'b1 || task_valid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_handoff: tready %b valid %b want 1/0", cmdin_if.tready, task_valid);
    end
    @(negedge clk);
    cmdin_if.tvalid = 1'b0;
    for (int i = 1; i < bq.size(); i++) send_beat(bq[i], i == bq.size() - 1, 8'd0);
    expect_task(c2, "b2b_second", 0);
  endtask

  task automatic test_reset_midcmd();
    cmd_t c;
    send_beat(hdr(EXEC, 8'd0, 1'b0), 1'b1, 8'd0);
    n_checks++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL pre_rst_err: got %b want 1", err); end
    c = rand_cmd(EXEC, 3);
    build_beats(c);
    for (int i = 0; i < 6; i++) send_beat(bq[i], 1'b0, 8'd0);
    cmdin_if.tvalid = 1'b1;
    cmdin_if.tdata  = bq[6];
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (cmdin_if.tready !== 1'b0 || task_valid !== 1'b0 || err !== 1'b0 || inst_valid !== 1'b0 ||
        task_tid !== 64'd0 || task_ptid !== 64'd0 || task_nrep !== 32'd1 || task_nargs !== 4'd0 ||
        arg_rdata !== 64'd0) begin
      n_fail++;
      $display("FAIL midrst: tready %b valid %b err %b tid %h nrep %0d nargs %0d want 0/0/0/0/1/0",
               cmdin_if.tready, task_valid, err, task_tid, task_nrep, task_nargs);
    end
    rst = 1'b0;
    cmdin_if.tvalid = 1'b0;
    @(negedge clk);
    c = rand_cmd(EXEC, 3);
    build_beats(c);
    send_cmd();
    expect_task(c, "after_rst", 1);
  endtask

  task automatic test_random();
    cmd_t c;
    for (int k = 0; k < 10; k++) begin
      c = rand_cmd(($urandom_range(0, 1) == 0) ? EXEC : PERI, int'($urandom_range(0, 15)));
      build_beats(c);
      send_cmd();
      expect_task(c, $sformatf("rand%0d", k), int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    rst = 1'b1;
    task_ready = 1'b0;
    err_clr = 1'b0;
    arg_raddr = 4'd0;
    cmdin_if.tvalid = 1'b0;
    cmdin_if.tdata  = '0;
    cmdin_if.tlast  = 1'b0;
    cmdin_if.tdest  = 8'd0;
    @(negedge clk);
    test_reset();
    test_exec();
    test_peri();
    test_inst();
    test_bad_index();
    test_header_errors();
    test_back_to_back();
    test_reset_midcmd();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
